riscv_keypad_scanner: RTL

Scans a 4x4 matrix keypad, synchronises and debounces it, and produces the 5-bit keyboard word read by the CPU IO bridge at the keyboard IO address. Bit 4 is the key-held flag and bits 3:0 are the key code. It sits directly upstream of the IO bridge's keyboard input. Column strobes go out to the board pins and row senses come in from them.

---
 rtl/riscv_keypad_scanner.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/riscv_keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row sync, debounce, keyboard word.
// Optional auto-repeat of key_event while held: define KEYPAD_REPEAT_EN.
module riscv_keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [4:0] keyboard,
    output logic       key_event
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    if (SCAN_DIV < 4 || DEBOUNCE_TICKS < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("riscv_keypad_scanner: invalid parameters");
    end

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEB,
        S_HELD,
        S_REL
    } state_t;

    logic [TW-1:0] tcnt_q;
    logic [TW-1:0] tcnt_d;
    logic          tick;
    logic [3:0]    r1_q;
    logic [3:0]    row_s;
    logic [1:0]    hit_row;
    state_t        state_q;
    logic [1:0]    col_idx_q;
    logic [1:0]    cand_row_q;
    logic [3:0]    cand_code_q;
    logic [DW-1:0] dcnt_q;
    logic [4:0]    kb_q;
    logic          kev_q;

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    logic [RW-1:0] rcnt_q;
    logic          rep_q;
    logic [RW-1:0] rlim;

    // Terminal count: initial delay first, then the repeat period.
    always_comb begin
        rlim = rep_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    end
`endif

    // Scan tick divider, one-cycle tick at the top of the count.
    always_comb begin
        tick   = (tcnt_q == TW'(SCAN_DIV - 1));
        tcnt_d = tick ? '0 : tcnt_q + TW'(1);
    end

    // Free-running tick counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    // Two-flop synchroniser for the asynchronous row senses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_q  <= 4'hF;
            row_s <= 4'hF;
        end else begin
            r1_q  <= row_in;
            row_s <= r1_q;
        end
    end

    // Lowest low row index wins when several rows are active.
    always_comb begin
        hit_row = 2'd3;
        if (!row_s[2]) hit_row = 2'd2;
        if (!row_s[1]) hit_row = 2'd1;
        if (!row_s[0]) hit_row = 2'd0;
    end

    // Scan / debounce / hold / release sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_SCAN;
            col_idx_q   <= 2'd0;
            cand_row_q  <= 2'd0;
            cand_code_q <= 4'd0;
            dcnt_q      <= '0;
            kb_q        <= 5'd0;
            kev_q       <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rcnt_q      <= '0;
            rep_q       <= 1'b0;
`endif
        end else begin
            kev_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    S_SCAN: begin
                        if (row_s != 4'hF) begin
                            cand_row_q  <= hit_row;
                            cand_code_q <= {hit_row, col_idx_q};
                            dcnt_q      <= '0;
                            state_q     <= S_DEB;
                        end else begin
                            col_idx_q <= col_idx_q + 2'd1;
                        end
                    end
                    S_DEB: begin
                        if (row_s[cand_row_q]) begin
                            state_q   <= S_SCAN;
                            col_idx_q <= col_idx_q + 2'd1;
                            dcnt_q    <= '0;
                        end else if (dcnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
                            state_q <= S_HELD;
                            kb_q    <= {1'b1, cand_code_q};
                            kev_q   <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rcnt_q  <= '0;
                            rep_q   <= 1'b0;
`endif
                        end else begin
                            dcnt_q <= dcnt_q + DW'(1);
                        end
                    end
                    S_HELD: begin
                        if (row_s[cand_row_q]) begin
                            state_q <= S_REL;
                            dcnt_q  <= '0;
                        end
`ifdef KEYPAD_REPEAT_EN
                        else if (rcnt_q == rlim) begin
                            rcnt_q <= '0;
                            rep_q  <= 1'b1;
                            kev_q  <= 1'b1;
                        end else begin
                            rcnt_q <= rcnt_q + RW'(1);
                        end
`endif
                    end
                    S_REL: begin
                        if (!row_s[cand_row_q]) begin
                            state_q <= S_HELD;
                            dcnt_q  <= '0;
                        end else if (dcnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
                            state_q   <= S_SCAN;
                            kb_q      <= {1'b0, cand_code_q};
                            col_idx_q <= col_idx_q + 2'd1;
                            dcnt_q    <= '0;
                        end else begin
                            dcnt_q <= dcnt_q + DW'(1);
                        end
                    end
                    default: state_q <= S_SCAN;
                endcase
            end
        end
    end

    assign col_out   = ~(4'b0001 << col_idx_q);
    assign keyboard  = kb_q;
    assign key_event = kev_q;

endmodule
